// File: rtl/led_pkg.sv
// led_pkg: shared brightness type, full-scale constant and end-level helper for led_fader
package led_pkg;
    localparam int PWM_BITS_DEF = 8;
    typedef logic [PWM_BITS_DEF-1:0] level_t;
    localparam level_t LVL_MAX = '1;
    function automatic logic [31:0] lvl_end(input bit tgt, input int unsigned bits = PWM_BITS_DEF);
        return tgt ? ((32'd1 << bits) - 32'd1) : 32'd0;
    endfunction
endpackage

// File: rtl/led_fader_chan.sv
// led_fader_chan: one LED channel, saturating fade level plus registered PWM compare
module led_fader_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                en,
    input  logic                target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                at_end
);
    localparam logic [PWM_BITS-1:0] LMAX = '1;
    logic [PWM_BITS-1:0] lvl, lvl_nxt, end_v;
    always_comb begin
        end_v   = PWM_BITS'(lvl_end(target, PWM_BITS));
        lvl_nxt = !tick ? lvl
                : (target && lvl != LMAX) ? lvl + PWM_BITS'(1)
                : (!target && lvl != '0) ? lvl - PWM_BITS'(1)
                : lvl;
    end
    assign at_end = (lvl == end_v);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl <= '0;
            led <= 1'b0;
        end else begin
            lvl <= lvl_nxt;
            led <= en & ((lvl == LMAX) | (pwm_cnt < lvl));
        end
    end
endmodule

// File: rtl/led_fader.sv
// led_fader: turns an on/off LED pattern into smoothly ramped PWM-dimmed LED drives
module led_fader
    import led_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pat_valid,
    input  logic [N_LEDS-1:0] pat_in,
    output logic [N_LEDS-1:0] leds_out,
    output logic              busy
);
    localparam int PW = $clog2(FADE_DIV);
    logic [N_LEDS-1:0]   target, at_end;
    logic [PW-1:0]       presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    // gated by en so a prescaler frozen at its last count cannot keep stepping levels
    assign tick = en && (presc == PW'(FADE_DIV - 1));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target  <= '0;
            presc   <= '0;
            pwm_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            if (pat_valid) target <= pat_in;
            if (en) presc <= tick ? '0 : presc + PW'(1);
            pwm_cnt <= en ? pwm_cnt + PWM_BITS'(1) : '0;
            busy    <= ~&at_end;
        end
    end
    for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
        led_fader_chan #(.PWM_BITS(PWM_BITS)) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .en     (en),
            .target (target[i]),
            .pwm_cnt(pwm_cnt),
            .led    (leds_out[i]),
            .at_end (at_end[i])
        );
    end
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: randomized scoreboard bench for led_fader against a behavioural model
module tb_led_fader;
    localparam int NL = 8, PB = 4, FD = 4, LMAX = 15;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0, en = 1'b0, pat_valid = 1'b0;
    logic [NL-1:0] pat_in = '0;
    logic [NL-1:0] leds_out;
    logic          busy;
    int            n_checks = 0, n_fail = 0;
    logic [NL:0]   exp_q[$];
    logic [NL:0]   exp_v;
    int            m_lvl[NL];
    int            m_tgt[NL];
    int            m_en_cycles = 0, m_pwm = 0;
    logic [NL-1:0] m_leds = '0;
    logic          m_busy = 1'b0;

    led_fader #(.N_LEDS(NL), .PWM_BITS(PB), .FADE_DIV(FD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pat_valid(pat_valid),
        .pat_in(pat_in), .leds_out(leds_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // reference: levels move one unit toward their target every FD enabled cycles
    task automatic model_edge(input bit r, input bit e, input bit pv, input logic [NL-1:0] p);
        bit step_now;
        if (!r) begin
            foreach (m_lvl[i]) begin m_lvl[i] = 0; m_tgt[i] = 0; end
            m_en_cycles = 0; m_pwm = 0; m_leds = '0; m_busy = 1'b0;
            return;
        end
        step_now = e && (m_en_cycles % FD == FD - 1);
        m_busy = 1'b0;
        foreach (m_lvl[i]) begin
            m_leds[i] = e && (m_lvl[i] == LMAX || m_pwm < m_lvl[i]);
            if (m_lvl[i] != m_tgt[i] * LMAX) m_busy = 1'b1;
        end
        if (step_now)
            foreach (m_lvl[i])
                m_lvl[i] = m_tgt[i] ? ((m_lvl[i] + 1 > LMAX) ? LMAX : m_lvl[i] + 1)
                                    : ((m_lvl[i] - 1 < 0) ? 0 : m_lvl[i] - 1);
        if (e) begin
            m_en_cycles++;
            m_pwm = (m_pwm + 1) % (LMAX + 1);
        end else m_pwm = 0;
        if (pv) foreach (m_tgt[i]) m_tgt[i] = p[i];
    endtask

    task automatic step(input bit r, input bit e, input bit pv, input logic [NL-1:0] p);
        @(negedge clk);
        rst_n = r; en = e; pat_valid = pv; pat_in = p;
        model_edge(r, e, pv, p);
        exp_q.push_back({m_busy, m_leds});
    endtask

    task automatic run(input int n, input bit e);
        for (int k = 0; k < n; k++) step(1'b1, e, 1'b0, '0);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (leds_out !== exp_v[NL-1:0]) begin
                n_fail++;
                $display("FAIL leds_out at %0t: got %h expected %h", $time, leds_out, exp_v[NL-1:0]);
            end
            n_checks++;
            if (busy !== exp_v[NL]) begin
                n_fail++;
                $display("FAIL busy at %0t: got %b expected %b", $time, busy, exp_v[NL]);
            end
        end
    end

    initial begin
        int guard;
        for (int k = 0; k < 3; k++) step(1'b0, 1'(k), 1'b1, 8'hFF);
        run(200, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h01);
        run(80, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        run(70, 1'b1);
        // reversal: load a falling target exactly on the tick that takes lvl0 from 8 to 9
        step(1'b1, 1'b1, 1'b1, 8'h01);
        guard = 0;
        while (!(m_lvl[0] == 8 && m_en_cycles % FD == FD - 1) && guard < 200) begin
            step(1'b1, 1'b1, 1'b0, '0);
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL reversal_setup: waited %0d cycles, limit 200", guard);
        end
        step(1'b1, 1'b1, 1'b1, 8'h00);
        run(80, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        run(100, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hA5);
        run(30, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        run(30, 1'b1);
        run(50, 1'b0);
        run(80, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        run(80, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        guard = 0;
        while (m_lvl[0] != 10 && guard < 200) begin
            step(1'b1, 1'b1, 1'b0, '0);
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL reset_setup: waited %0d cycles, limit 200", guard);
        end
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        run(20, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 29) != 0) ? en | ($urandom_range(0, 9) == 0) : ~en,
                 ($urandom_range(0, 39) == 0),
                 NL'($urandom));
        end
        run(5, 1'b1);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream consumer of the counter stage's 8-bit LED pattern.
- Turns each on/off pattern bit into a PWM-dimmed LED output that ramps up or down smoothly, instead of switching abruptly.
- Sits between the pattern source and the board LED pins.
- Per-LED brightness levels, a shared fade prescaler and a shared PWM counter.

Parameters:
N_LEDS, 8, number of LED channels
PWM_BITS, 8, width of brightness level and PWM counter; LVL_MAX = 2**PWM_BITS-1
FADE_DIV, 65536, clock cycles per fade step (>=2); full ramp = LVL_MAX*FADE_DIV cycles

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
en  in  1  1 = normal operation; 0 = freeze fade and blank outputs
pat_valid  in  1  strobe: load pat_in as the new target pattern
pat_in  in  N_LEDS  target pattern, 1 = LED should be on
leds_out  out  N_LEDS  registered PWM drive per LED
busy  out  1  registered; 1 while any level differs from its target end value

Behaviour:
- Reset (rst_n=0 at a clk edge): the following all go to 0 at that edge, regardless of other inputs:
  - target
  - every lvl[i]
  - prescaler (presc)
  - pwm_cnt
  - leds_out
  - busy
- Reset asserted mid-fade aborts the fade; no ramp-down.
- target register: loaded from pat_in at any edge where rst_n=1 and pat_valid=1. Loading is independent of en.
- Prescaler: counts 0..FADE_DIV-1 while en=1 and wraps to 0. tick=1 in the cycle where presc==FADE_DIV-1. Holds its value while en=0.
- Fade step, on a tick edge, per channel i:
  - target[i]=1 and lvl[i]<LVL_MAX: lvl+1.
  - target[i]=0 and lvl[i]>0: lvl-1.
  - Otherwise hold; saturate at both ends, no wrap.
- pat_valid and tick at the same edge: the step uses the OLD target. The new target takes effect from the next tick.
- A target reversal mid-ramp reverses direction from the current level; there is no jump.
- PWM counter: PWM_BITS wide, increments every cycle while en=1, wraps LVL_MAX->0. Forced to 0 while en=0.
- Output, registered, one cycle after the compare:
  - leds_out[i] <= en & ((lvl[i]==LVL_MAX) | (pwm_cnt < lvl[i])).
  - lvl=0 gives constant 0; lvl=LVL_MAX gives constant 1; otherwise duty = lvl/2**PWM_BITS.
- busy <= OR over i of (lvl[i] != (target[i] ? LVL_MAX : 0)). It uses the values present before the edge, so it lags one cycle.
- en falling: leds_out is 0 from the next edge; levels and presc freeze.
- en rising: presc resumes from its held value; pwm_cnt restarts at 0.
- All arithmetic is unsigned at PWM_BITS width (presc at $clog2(FADE_DIV)); no combinational path from inputs to outputs.

Decomposition:
- Package led_pkg holds:
  - typedef level_t = logic [PWM_BITS-1:0] (package parameter mirrors the default)
  - LVL_MAX constant
  - function lvl_end(bit tgt) returning LVL_MAX or 0
- Sub-module led_fader_chan: one channel.
  - Inputs: clk, rst_n, tick, en, target bit, pwm_cnt.
  - Outputs: led, at_end.
  - Holds lvl and the output flop.
- led_fader owns target, presc, pwm_cnt and busy, and generates N_LEDS channels.

Test Plan (bench overrides PWM_BITS=4, FADE_DIV=4; LVL_MAX=15):
1. Reset hold -> leds_out=0x00, busy=0; then rst_n=1, en=1, no pat_valid for 200 cycles -> outputs stay 0x00, busy=0.
2. Fade-in:
   - Stimulus: pat_in=0x01 with pat_valid for 1 cycle.
   - Check: busy=1 from the next edge.
   - Check: lvl0 reaches 15 after 15 ticks (~60 cycles), with busy=0 one cycle later.
   - Check: leds_out[0] is then constantly 1.
   - Check: at lvl0=4, bit0 high exactly 4 of every 16 cycles.
3. Reversal:
   - Stimulus: with lvl0=8 rising, load pat_in=0x00 at an edge coinciding with a tick.
   - Check: lvl0 becomes 9 at that edge, then 8, 7, ... 0 on subsequent ticks.
   - Check: leds_out[0]=0 steady, busy=0 at the end.
4. Saturation and mixed channels:
   - Stimulus: pat_in=0xA5 held until all channels settle, then pattern reloaded with 0xA5.
   - Check: bits 7,5,2,0 constant 1; others constant 0.
   - Check: reloading 0xA5 leaves busy=0; no wrap past 15 or below 0.
5. Enable gating:
   - Stimulus: en=0 mid-ramp for 50 cycles.
   - Check: leds_out=0x00 from the next edge; levels and presc unchanged during the gap.
   - Check: after en=1, the ramp continues from the frozen level; pwm_cnt restarts at 0.
6. Reset mid-fade:
   - Stimulus: rst_n=0 for 1 cycle with lvl=10 on all channels, pat_valid=1 in the same cycle.
   - Check: the next cycle shows leds_out=0x00, busy=0, target=0x00 (pat_valid ignored).
